// File: rtl/acq_frame_sequencer_pkg.sv
// Shared definitions for the acquisition frame sequencer:
// state codes, control/status field positions and status packing.
package acq_frame_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    localparam int CTRL_ENABLE  = 0;
    localparam int CTRL_CLEAR   = 1;
    localparam int CTRL_CONT    = 2;
    localparam int CTRL_NFR_LSB = 16;
    localparam int NFR_W        = 16;

    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_DONE      = 2;
    localparam int STAT_ABORT     = 3;
    localparam int STAT_OVERRUN   = 4;
    localparam int STAT_COUNT_LSB = 8;
    localparam int COUNT_W        = 24;

    function automatic logic [31:0] pack_status(
        input seq_state_t         st,
        input logic               done,
        input logic               abort,
        input logic               overrun,
        input logic [COUNT_W-1:0] count
    );
        logic [31:0] s;
        s = '0;
        s[STAT_STATE_LSB +: 2]       = st;
        s[STAT_DONE]                 = done;
        s[STAT_ABORT]                = abort;
        s[STAT_OVERRUN]              = overrun;
        s[STAT_COUNT_LSB +: COUNT_W] = count;
        return s;
    endfunction

endpackage

// File: rtl/acq_frame_sequencer_timer.sv
// Frame slot period counter; runs only while the sequencer is in RUN
// and reports the last cycle of a slot and the start of the next one.
module frame_period_timer #(
    parameter int CYCLES_PER_FRAME = 2800
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic start,
    output logic slot,
    output logic tc
);

    localparam int W = (CYCLES_PER_FRAME > 1) ? $clog2(CYCLES_PER_FRAME) : 1;
    localparam logic [W-1:0] LAST = W'(CYCLES_PER_FRAME - 1);

    logic [W-1:0] period_cnt;

    assign tc = run && (period_cnt == LAST);
    // slot means a new slot begins in the following cycle
    assign slot = start || tc;

    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt <= '0;
        end else if (run && !tc) begin
            period_cnt <= period_cnt + 1'b1;
        end else begin
            period_cnt <= '0;
        end
    end

endmodule

// File: rtl/acq_frame_sequencer.sv
// Acquisition frame sequencer: arms on enable, issues periodic
// frame_start strobes for the SPI engine and reports status.
module acq_frame_sequencer
    import acq_frame_sequencer_pkg::*;
#(
    parameter int CYCLES_PER_FRAME = 2800,
    parameter int ARM_CYCLES       = 4
) (
    input  logic        pl_clk,
    input  logic        pl_rst,
    input  logic [31:0] control_reg_pl,
    input  logic        spi_busy,
    output logic        frame_start,
    output logic [31:0] status_reg_pl
);

    localparam int AW = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CYCLES - 1);

    seq_state_t         state;
    logic               en_q;
    logic               clr_q;
    logic [AW-1:0]      arm_cnt;
    logic               cfg_cont;
    logic [NFR_W-1:0]   cfg_n;
    logic [NFR_W-1:0]   slot_cnt;
    logic               done_sticky;
    logic               abort_sticky;
    logic               overrun_sticky;
    logic [COUNT_W-1:0] frame_count;

    logic               enable;
    logic               clear;
    logic               cont;
    logic [NFR_W-1:0]   nfr;
    logic               unused_ctrl;

    logic en_rise;
    logic en_fall;
    logic clr_edge;
    logic arm_end;
    logic arm_empty;
    logic run_start;
    logic fin_end;
    logic slot;
    logic tc;
    logic slot_start;

    assign enable      = control_reg_pl[CTRL_ENABLE];
    assign clear       = control_reg_pl[CTRL_CLEAR];
    assign cont        = control_reg_pl[CTRL_CONT];
    assign nfr         = control_reg_pl[CTRL_NFR_LSB +: NFR_W];
    assign unused_ctrl = ^control_reg_pl[CTRL_NFR_LSB-1:CTRL_CONT+1];

    assign en_rise  = enable && !en_q;
    assign en_fall  = !enable && en_q;
    assign clr_edge = clear && !clr_q;

    assign arm_end   = (state == ST_ARM) && (arm_cnt == ARM_LAST) && !en_fall;
    assign arm_empty = !cont && (nfr == '0);
    assign run_start = arm_end && !arm_empty;
    assign fin_end   = (state == ST_RUN) && !cfg_cont
                     && (slot_cnt == cfg_n) && tc;
    // a slot is only opened if the run is not ending on this edge
    assign slot_start = slot && !en_fall && !fin_end;

    frame_period_timer #(
        .CYCLES_PER_FRAME(CYCLES_PER_FRAME)
    ) u_timer (
        .clk  (pl_clk),
        .rst  (pl_rst),
        .run  (state == ST_RUN),
        .start(run_start),
        .slot (slot),
        .tc   (tc)
    );

    always_ff @(posedge pl_clk) begin
        if (pl_rst) begin
            state          <= ST_IDLE;
            en_q           <= 1'b0;
            clr_q          <= 1'b0;
            arm_cnt        <= '0;
            cfg_cont       <= 1'b0;
            cfg_n          <= '0;
            slot_cnt       <= '0;
            done_sticky    <= 1'b0;
            abort_sticky   <= 1'b0;
            overrun_sticky <= 1'b0;
            frame_count    <= '0;
            frame_start    <= 1'b0;
            status_reg_pl  <= '0;
        end else begin
            en_q          <= enable;
            clr_q         <= clear;
            frame_start   <= slot_start && !spi_busy;
            status_reg_pl <= pack_status(state, done_sticky, abort_sticky,
                                         overrun_sticky, frame_count);

            if (clr_edge) begin
                frame_count    <= '0;
                overrun_sticky <= 1'b0;
            end else begin
                if (slot_start && !spi_busy) begin
                    frame_count <= frame_count + 1'b1;
                end
                if (slot_start && spi_busy) begin
                    overrun_sticky <= 1'b1;
                end
            end

            if (arm_end) begin
                slot_cnt <= NFR_W'(run_start);
            end else if (slot_start) begin
                slot_cnt <= slot_cnt + 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (en_rise) begin
                        state        <= ST_ARM;
                        arm_cnt      <= '0;
                        done_sticky  <= 1'b0;
                        abort_sticky <= 1'b0;
                    end
                end
                ST_ARM: begin
                    if (en_fall) begin
                        state <= ST_IDLE;
                    end else begin
                        arm_cnt <= arm_cnt + 1'b1;
                        if (arm_end) begin
                            cfg_cont <= cont;
                            cfg_n    <= nfr;
                            if (arm_empty) begin
                                state       <= ST_DONE;
                                done_sticky <= 1'b1;
                            end else begin
                                state <= ST_RUN;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (en_fall) begin
                        state        <= ST_IDLE;
                        abort_sticky <= 1'b1;
                    end else if (fin_end) begin
                        state       <= ST_DONE;
                        done_sticky <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (en_fall) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acq_frame_sequencer.sv
// Directed bench for acq_frame_sequencer with CYCLES_PER_FRAME=8
// and ARM_CYCLES=4; expected values are hand-computed cycle offsets.
module tb_acq_frame_sequencer;

    localparam int CPF = 8;
    localparam int ARM = 4;

    logic        pl_clk = 1'b0;
    logic        pl_rst = 1'b1;
    logic [31:0] control_reg_pl = '0;
    logic        spi_busy = 1'b0;
    logic        frame_start;
    logic [31:0] status_reg_pl;

    int cyc = 0;
    int t0 = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int strobes[$];

    acq_frame_sequencer #(
        .CYCLES_PER_FRAME(CPF),
        .ARM_CYCLES      (ARM)
    ) dut (
        .pl_clk        (pl_clk),
        .pl_rst        (pl_rst),
        .control_reg_pl(control_reg_pl),
        .spi_busy      (spi_busy),
        .frame_start   (frame_start),
        .status_reg_pl (status_reg_pl)
    );

    always #5 pl_clk = ~pl_clk;

    always @(posedge pl_clk) cyc <= cyc + 1;

    always @(negedge pl_clk) begin
        if (frame_start) strobes.push_back(cyc);
    end

    task automatic adv(input int n);
        repeat (n) @(posedge pl_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int soff(input int i);
        return (i < strobes.size()) ? strobes[i] - t0 : -1;
    endfunction

    task automatic clear_pulse();
        control_reg_pl = 32'h2;
        adv(1);
        control_reg_pl = 32'h0;
        adv(2);
    endtask

    initial begin
        adv(2);
        pl_rst = 1'b0;
        adv(1);
        chk("reset_status", status_reg_pl, 32'h0);
        chk("reset_strobe", {31'b0, frame_start}, 32'h0);

        // finite run, N=3
        strobes.delete();
        t0 = cyc;
        control_reg_pl = 32'h0003_0001;
        adv(29);
        chk("fin_last_run", status_reg_pl, 32'h0000_0302);
        adv(1);
        chk("fin_done", status_reg_pl, 32'h0000_0307);
        chk("fin_count", strobes.size(), 3);
        chk("fin_s0", soff(0), 5);
        chk("fin_s1", soff(1), 13);
        chk("fin_s2", soff(2), 21);
        control_reg_pl = 32'h0;
        adv(3);
        chk("fin_idle", status_reg_pl, 32'h0000_0304);
        clear_pulse();
        chk("clr_idle", status_reg_pl, 32'h0000_0004);

        // continuous, enable held for 100 cycles
        strobes.delete();
        t0 = cyc;
        control_reg_pl = 32'h5;
        adv(100);
        control_reg_pl = 32'h0;
        adv(4);
        chk("cont_status", status_reg_pl, 32'h0000_0C08);
        chk("cont_count", strobes.size(), 12);
        chk("cont_first", soff(0), 5);
        chk("cont_last", soff(11), 93);

        // overrun on second slot of N=3
        clear_pulse();
        chk("clr_abort_kept", status_reg_pl, 32'h0000_0008);
        strobes.delete();
        t0 = cyc;
        control_reg_pl = 32'h0003_0001;
        adv(10);
        spi_busy = 1'b1;
        adv(6);
        spi_busy = 1'b0;
        adv(13);
        chk("ovr_last_run", status_reg_pl, 32'h0000_0212);
        adv(1);
        chk("ovr_done", status_reg_pl, 32'h0000_0217);
        chk("ovr_count", strobes.size(), 2);
        chk("ovr_s0", soff(0), 5);
        chk("ovr_s1", soff(1), 21);
        control_reg_pl = 32'h0;
        adv(3);
        chk("ovr_idle", status_reg_pl, 32'h0000_0214);

        // short enable pulse
        strobes.delete();
        t0 = cyc;
        control_reg_pl = 32'h1;
        adv(2);
        chk("short_arm", status_reg_pl, 32'h0000_0211);
        control_reg_pl = 32'h0;
        adv(8);
        chk("short_idle", status_reg_pl, 32'h0000_0210);
        chk("short_nostrobe", strobes.size(), 0);

        // clear edge coincident with a strobe
        strobes.delete();
        t0 = cyc;
        control_reg_pl = 32'h5;
        adv(13);
        chk("clr_strobe_hi", {31'b0, frame_start}, 32'h1);
        chk("clr_before", status_reg_pl, 32'h0000_0312);
        control_reg_pl = 32'h7;
        adv(1);
        control_reg_pl = 32'h5;
        adv(1);
        chk("clr_after", status_reg_pl, 32'h0000_0002);
        adv(7);
        chk("clr_next", status_reg_pl, 32'h0000_0102);

        // reset during RUN, just before a strobe
        adv(6);
        pl_rst = 1'b1;
        adv(1);
        chk("rst_run_strobe", {31'b0, frame_start}, 32'h0);
        chk("rst_run_status", status_reg_pl, 32'h0);
        pl_rst = 1'b0;
        strobes.delete();
        t0 = cyc;
        adv(6);
        chk("rst_rearm_count", strobes.size(), 1);
        chk("rst_rearm_s0", soff(0), 5);
        chk("rst_rearm_status", status_reg_pl, 32'h0000_0102);
        control_reg_pl = 32'h0;
        adv(3);
        chk("rst_abort", status_reg_pl, 32'h0000_0108);

        // N=0 finite
        strobes.delete();
        t0 = cyc;
        control_reg_pl = 32'h1;
        adv(5);
        chk("n0_arm", status_reg_pl, 32'h0000_0101);
        adv(1);
        chk("n0_done", status_reg_pl, 32'h0000_0107);
        adv(10);
        chk("n0_nostrobe", strobes.size(), 0);
        chk("n0_hold", status_reg_pl, 32'h0000_0107);
        control_reg_pl = 32'h0;
        adv(3);
        chk("n0_idle", status_reg_pl, 32'h0000_0104);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
